// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped UART transmitter. Bytes written to DATA are queued in a small
//   FIFO and sent 8N1, LSB first, on tx. The same bus also reads and writes
//   STATUS and BAUD_DIV.
//
//   Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
//   between the last data bit and the stop bit. The frame is then 11 bit
//   periods long instead of 10.
//
// Parameters
//   FIFO_DEPTH        TX FIFO entries (power of two, 2..64)
//   DEFAULT_BAUD_DIV  reset value of BAUD_DIV (clocks per bit)
//
// Ports
//   clk      core clock, rising edge
//   rstb     asynchronous active-low reset
//   sel      peripheral selected by bus decode
//   addr     byte offset; addr[3:2] picks the register
//   wr_ena   write strobe, qualified by sel
//   wr_data  write data
//   rd_data  registered read data, valid the cycle after sel/addr
//   tx       serial output, idles high
//   irq      high while the FIFO is empty and the shifter is idle
//
// Register map (addr[3:2])
//   0 DATA      W: push wr_data[7:0]           R: 0
//   1 STATUS    R: [0] busy [1] full [2] empty [3] overflow [11:8] count
//               W: bit3=1 clears overflow
//   2 BAUD_DIV  RW [15:0]; a written value of 0 or 1 is stored as 2
//   3 reserved  R: 0, writes ignored
//
// FSM
//   state    | meaning
//   S_IDLE   | line high; pops the FIFO head as soon as one is available
//   S_START  | start bit (tx=0)
//   S_DATA   | 8 data bits, LSB first
//   S_PARITY | even parity bit (only with UART_TX_PARITY_EN)
//   S_STOP   | stop bit (tx=1); chains straight into the next START if data waits
module mmio_uart_tx #(
    parameter int FIFO_DEPTH       = 8,
    parameter int DEFAULT_BAUD_DIV = 534
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic        wr_ena,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t         state_q, state_d;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           overflow_q;
    logic [15:0]    baud_div_q;
    logic [15:0]    baud_cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shreg_q;
`ifdef UART_TX_PARITY_EN
    logic           parity_q;
`endif

    logic           full, empty, busy;
    logic           wr_data_reg, wr_status_reg, wr_baud_reg;
    logic           push_ok, push_drop;
    logic           pop, bit_start, shift_en, idx_clr;
    logic           bit_end;
    logic [3:0]     cnt_sat;
    logic [31:0]    status_word;
    logic           unused_ok;

    assign unused_ok = ^{addr[1:0], wr_data[31:16]};

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign busy  = (state_q != S_IDLE);
    assign irq   = empty & ~busy;

    assign wr_data_reg   = sel & wr_ena & (addr[3:2] == 2'd0);
    assign wr_status_reg = sel & wr_ena & (addr[3:2] == 2'd1);
    assign wr_baud_reg   = sel & wr_ena & (addr[3:2] == 2'd2);

    // A push into a full FIFO still fits when the shifter pops in the same cycle.
    assign push_ok   = wr_data_reg & (~full | pop);
    assign push_drop = wr_data_reg & full & ~pop;

    assign bit_end = (baud_cnt_q == 16'd0);

    always_comb begin
        if (32'(count_q) > 32'd15) cnt_sat = 4'hF;
        else                       cnt_sat = 4'(count_q);
    end

    assign status_word = {20'd0, cnt_sat, 4'd0, overflow_q, empty, full, busy};

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        bit_start = 1'b0;
        shift_en  = 1'b0;
        idx_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    bit_start = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_start = 1'b1;
                    idx_clr   = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_start = 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    bit_start = 1'b1;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        bit_start = 1'b1;
                        state_d   = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx = parity_q;
`endif
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Bit timer and shifter. BAUD_DIV is sampled only at bit starts, so a
    // mid-frame write lands at the next bit boundary.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'd0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            if (bit_start)             baud_cnt_q <= baud_div_q - 16'd1;
            else if (!bit_end)         baud_cnt_q <= baud_cnt_q - 16'd1;

            if (idx_clr)               bit_idx_q <= 3'd0;
            else if (shift_en)         bit_idx_q <= bit_idx_q + 3'd1;

            if (pop) begin
                shreg_q  <= mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                parity_q <= ^mem[rd_ptr_q];
`endif
            end else if (shift_en) begin
                shreg_q <= {1'b0, shreg_q[7:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wr_data[7:0];
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_ok) - CW'(pop);
            if (push_drop)                        overflow_q <= 1'b1;
            else if (wr_status_reg && wr_data[3]) overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            baud_div_q <= 16'(DEFAULT_BAUD_DIV);
        end else if (wr_baud_reg) begin
            if (wr_data[15:0] < 16'd2) baud_div_q <= 16'd2;
            else                       baud_div_q <= wr_data[15:0];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_data <= 32'd0;
        end else if (sel) begin
            case (addr[3:2])
                2'd1:    rd_data <= status_word;
                2'd2:    rd_data <= {16'd0, baud_div_q};
                default: rd_data <= 32'd0;
            endcase
        end else begin
            rd_data <= 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        rstb;
    logic        sel;
    logic [3:0]  addr;
    logic        wr_ena;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    bit         exp_q[$];
    logic [7:0] tx_bytes[$];

    always #5 clk = ~clk;

    mmio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_BAUD_DIV(534)) dut (
        .clk(clk), .rstb(rstb), .sel(sel), .addr(addr), .wr_ena(wr_ena),
        .wr_data(wr_data), .rd_data(rd_data), .tx(tx), .irq(irq)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level, one entry per clock, for one frame.
    function automatic void push_frame(input logic [7:0] b, input int div);
        bit bits[$];
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[j])
            for (int r = 0; r < div; r++) exp_q.push_back(bits[j]);
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wr_ena = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        sel = 1'b0; wr_ena = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wr_ena = 1'b0; addr = a;
        @(negedge clk);
        d = rd_data;
        sel = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
    endtask

    // Sets BAUD_DIV, writes tx_bytes on consecutive cycles and checks tx/irq
    // every clock against the expected waveform. Returns cycles from the first
    // low on tx until irq rises.
    task automatic run_stream(input int div, input string name, output int low_to_idle);
        int total, n, low_start;
        bit seen_low, seen_idle;
        bit exp_tx, exp_irq;
        bus_write(4'h8, 32'(div));
        exp_q.delete();
        exp_q.push_back(1'b1);
        foreach (tx_bytes[j]) push_frame(tx_bytes[j], div);
        total = exp_q.size();
        n = tx_bytes.size();
        seen_low = 0; seen_idle = 0; low_start = 0; low_to_idle = -1;
        for (int i = 0; i <= total + 3; i++) begin
            if (i > 0) begin
                exp_tx  = (i - 1 < total) ? exp_q[i-1] : 1'b1;
                exp_irq = (i - 1 < total) ? 1'b0 : 1'b1;
                n_checks++;
                if (tx !== exp_tx || irq !== exp_irq) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: tx=%b irq=%b, required tx=%b irq=%b",
                             name, i - 1, tx, irq, exp_tx, exp_irq);
                end
                if (!seen_low && tx === 1'b0) begin seen_low = 1; low_start = i; end
                if (seen_low && !seen_idle && irq === 1'b1) begin
                    seen_idle = 1; low_to_idle = i - low_start;
                end
            end
            if (i < n) begin
                sel = 1'b1; wr_ena = 1'b1; addr = 4'h0; wr_data = {24'hDEAD_BE, tx_bytes[i]};
            end else begin
                sel = 1'b0; wr_ena = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus_write(4'h8, 32'd8);
        bus_write(4'h0, 32'h00);
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (tx !== 1'b0) begin
            n_fail++; $display("FAIL reset_pre: tx=%b, required 0 (start bit)", tx);
        end
        #2 rstb = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b1 || rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_async: tx=%b irq=%b rd_data=%h, required 1 1 0", tx, irq, rd_data);
        end
        @(negedge clk);
        rstb = 1'b1;
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h0000_0004) begin
            n_fail++; $display("FAIL reset_status: got %h, required 00000004", d);
        end
        bus_read(4'h8, d);
        n_checks++;
        if (d !== 32'd534) begin
            n_fail++; $display("FAIL reset_baud: got %0d, required 534", d);
        end
    endtask

    task automatic test_single_frame();
        int dur;
        tx_bytes.delete(); tx_bytes.push_back(8'hA5);
        run_stream(4, "frame_a5", dur);
        n_checks++;
        if (dur !== FRAME_BITS * 4) begin
            n_fail++; $display("FAIL frame_a5_len: got %0d, required %0d", dur, FRAME_BITS * 4);
        end
    endtask

    task automatic test_back_to_back();
        int dur;
        tx_bytes.delete(); tx_bytes.push_back(8'h55); tx_bytes.push_back(8'h0F);
        run_stream(2, "b2b", dur);
        n_checks++;
        if (dur !== 2 * FRAME_BITS * 2) begin
            n_fail++; $display("FAIL b2b_len: got %0d, required %0d", dur, 2 * FRAME_BITS * 2);
        end
    endtask

    task automatic test_random();
        int dur, n, div;
        for (int it = 0; it < 6; it++) begin
            n   = $urandom_range(1, 4);
            div = $urandom_range(2, 6);
            tx_bytes.delete();
            for (int j = 0; j < n; j++) tx_bytes.push_back(8'($urandom));
            run_stream(div, "random", dur);
            n_checks++;
            if (dur !== n * FRAME_BITS * div) begin
                n_fail++;
                $display("FAIL random_len: got %0d, required %0d", dur, n * FRAME_BITS * div);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int nwr, exp_cnt;
        logic [31:0] exp_status;
        nwr = 10;
        bus_write(4'h8, 32'd1000);
        for (int i = 0; i < nwr; i++) begin
            @(negedge clk);
            sel = 1'b1; wr_ena = 1'b1; addr = 4'h0; wr_data = 32'(i + 1);
        end
        @(negedge clk);
        sel = 1'b0; wr_ena = 1'b0;
        // The shifter takes the first byte, the FIFO holds at most 8 more.
        exp_cnt = (nwr - 1 > 8) ? 8 : nwr - 1;
        exp_status = 32'(exp_cnt << 8) | 32'h1 | ((exp_cnt == 8) ? 32'h2 : 32'h0)
                   | ((nwr - 1 > 8) ? 32'h8 : 32'h0);
        bus_read(4'h4, d);
        n_checks++;
        if (d !== exp_status) begin
            n_fail++; $display("FAIL ovf_status: got %h, required %h", d, exp_status);
        end
        bus_write(4'h4, 32'h7);
        bus_read(4'h4, d);
        n_checks++;
        if (d !== exp_status) begin
            n_fail++; $display("FAIL ovf_keep: got %h, required %h", d, exp_status);
        end
        bus_write(4'h4, 32'h8);
        bus_read(4'h4, d);
        n_checks++;
        if (d !== (exp_status & ~32'h8)) begin
            n_fail++; $display("FAIL ovf_clear: got %h, required %h", d, exp_status & ~32'h8);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL ovf_irq: irq=%b, required 0", irq);
        end
        pulse_reset();
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL ovf_reset: got %h, required 00000004", d);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d, v, exp_v;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: v = 32'd0;
                1: v = 32'd1;
                2: v = 32'd2;
                default: v = $urandom;
            endcase
            exp_v = (v[15:0] < 16'd2) ? 32'd2 : {16'd0, v[15:0]};
            bus_write(4'h8, v);
            bus_read(4'h8, d);
            n_checks++;
            if (d !== exp_v) begin
                n_fail++; $display("FAIL baud_rw: wrote %h got %h, required %h", v, d, exp_v);
            end
        end
        bus_write(4'hC, 32'h1234_5678);
        bus_read(4'hC, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL reserved: got %h, required 0", d);
        end
        bus_read(4'h0, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL data_read: got %h, required 0", d);
        end
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL regs_status: got %h, required 00000004", d);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int dur;
        tx_bytes.delete(); tx_bytes.push_back(8'h07);
        run_stream(3, "parity_07", dur);
        n_checks++;
        if (dur !== 33) begin
            n_fail++; $display("FAIL parity_len: got %0d, required 33", dur);
        end
        tx_bytes.delete(); tx_bytes.push_back(8'h03);
        run_stream(3, "parity_03", dur);
    endtask
`endif

    initial begin
        rstb = 1'b0; sel = 1'b0; wr_ena = 1'b0; addr = 4'h0; wr_data = 32'd0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || irq !== 1'b1 || rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL por: tx=%b irq=%b rd_data=%h, required 1 1 0", tx, irq, rd_data);
        end
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random();
        test_overflow();
        test_regs();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
